// File: rtl/lms_pkg.sv
// rtl/lms_pkg.sv - shared state codes and default widths/shifts for the LMS adaptation controller
package lms_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_TRAIN = 3'd2,
      ST_TRACK = 3'd3,
      ST_HOLD  = 3'd4
   } lms_state_e;

   localparam int         LMS_EW       = 16;
   localparam int         LMS_WIN_LOG  = 4;
   localparam logic [2:0] LMS_MU_TRAIN = 3'd1;
   localparam logic [2:0] LMS_MU_TRACK = 3'd7;

endpackage

// File: rtl/lms_adapt_ctrl_if.sv
// rtl/lms_adapt_ctrl_if.sv - error-in / control-out bundle between LMS datapath and adaptation controller
interface lms_adapt_ctrl_if #(
   parameter int EW = lms_pkg::LMS_EW
) ();

   logic          sample_en;
   logic [EW-1:0] e_in;
   logic          coef_clr;
   logic          adapt_en;
   logic [2:0]    mu_shift;

   // controller side: consumes the filter error, drives the coefficient controls
   modport slave (
      input  sample_en,
      input  e_in,
      output coef_clr,
      output adapt_en,
      output mu_shift
   );

   // datapath side
   modport master (
      output sample_en,
      output e_in,
      input  coef_clr,
      input  adapt_en,
      input  mu_shift
   );

endinterface

// File: rtl/lms_err_win.sv
// rtl/lms_err_win.sv - saturating |e| window accumulator producing windowed mean and window-end strobe
module lms_err_win
   import lms_pkg::*;
#(
   parameter int EW      = LMS_EW,
   parameter int WIN_LOG = LMS_WIN_LOG
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          acc_en,
   input  logic [EW-1:0] e_in,
   output logic          win_done,
   output logic [EW-1:0] avg_new,
   output logic [EW-1:0] win_avg
);

   localparam int AW = EW + WIN_LOG;

   logic [EW-1:0]      e_abs;
   logic [AW-1:0]      acc_sum;
   logic [AW-1:0]      acc_q, acc_d;
   logic [WIN_LOG-1:0] cnt_q, cnt_d;
   logic [EW-1:0]      win_avg_q, win_avg_d;

   // |e| with the most negative code clamped so it still fits in EW-1 magnitude bits
   always_comb begin
      e_abs = e_in;
      if (e_in[EW-1]) begin
         if (e_in[EW-2:0] == '0) begin
            e_abs = {1'b0, {(EW-1){1'b1}}};
         end else begin
            e_abs = (~e_in) + 1'b1;
         end
      end
   end

   // running sum including the current sample; the window mean is taken from this so the
   // decision at window end sees the sample that completed the window
   always_comb begin
      acc_sum  = acc_q + {{WIN_LOG{1'b0}}, e_abs};
      avg_new  = acc_sum[AW-1:WIN_LOG];
      win_done = acc_en & (cnt_q == {WIN_LOG{1'b1}});
   end

   // accumulate, wrap the sample counter and latch the mean at window end
   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      win_avg_d = win_avg_q;
      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (acc_en) begin
         cnt_d = cnt_q + 1'b1;
         if (win_done) begin
            acc_d     = '0;
            win_avg_d = avg_new;
         end else begin
            acc_d = acc_sum;
         end
      end
   end

   // window state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         win_avg_q <= '0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         win_avg_q <= win_avg_d;
      end
   end

   assign win_avg = win_avg_q;

endmodule

// File: rtl/lms_adapt_ctrl.sv
// rtl/lms_adapt_ctrl.sv - LMS adaptation phase sequencer: clear, train, track, hold with error-window monitoring
module lms_adapt_ctrl
   import lms_pkg::*;
#(
   parameter int         EW       = LMS_EW,
   parameter int         WIN_LOG  = LMS_WIN_LOG,
   parameter int         CLR_CYC  = 2,
   parameter logic [2:0] MU_TRAIN = LMS_MU_TRAIN,
   parameter logic [2:0] MU_TRACK = LMS_MU_TRACK,
   parameter logic [7:0] MAX_WIN  = 8'd32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   lms_adapt_ctrl_if.slave     bus,
   input  logic [EW-1:0]       thr_conv,
   input  logic [EW-1:0]       thr_div,
   output logic [2:0]          state,
   output logic                converged,
   output logic                div_pulse,
   output logic                timeout,
   output logic [EW-1:0]       win_avg
);

   localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

   lms_state_e    state_q, state_d;
   logic [CW-1:0] clr_cnt_q, clr_cnt_d;
   logic [7:0]    win_cnt_q, win_cnt_d;
   logic          coef_clr_q, coef_clr_d;
   logic [2:0]    mu_shift_q, mu_shift_d;
   logic          converged_q, converged_d;
   logic          div_pulse_q, div_pulse_d;
   logic          timeout_q, timeout_d;

   logic          adapting;
   logic          win_clr;
   logic          win_acc_en;
   logic          win_done;
   logic [EW-1:0] avg_new;

   // updates and accumulation only run in the adapting phases; stop discards the partial window
   always_comb begin
      adapting   = (state_q == ST_TRAIN) || (state_q == ST_TRACK);
      win_clr    = stop || (state_q == ST_CLEAR);
      win_acc_en = bus.sample_en & adapting & ~stop;
   end

   lms_err_win #(
      .EW      (EW),
      .WIN_LOG (WIN_LOG)
   ) u_err_win (
      .clk      (clk),
      .rst_n    (reset),
      .clr      (win_clr),
      .acc_en   (win_acc_en),
      .e_in     (bus.e_in),
      .win_done (win_done),
      .avg_new  (avg_new),
      .win_avg  (win_avg)
   );

   // phase sequencing and window decisions; every registered output follows the next state
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      win_cnt_d   = win_cnt_q;
      timeout_d   = timeout_q;
      div_pulse_d = 1'b0;

      if (stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
               if (clr_cnt_q == CW'(CLR_CYC - 1)) begin
                  state_d = ST_TRAIN;
               end else begin
                  clr_cnt_d = clr_cnt_q + 1'b1;
               end
            end
            ST_TRAIN: begin
               if (win_done) begin
                  if (avg_new < thr_conv) begin
                     state_d = ST_TRACK;
                  end else begin
                     win_cnt_d = win_cnt_q + 8'd1;
                     if (win_cnt_d == MAX_WIN) begin
                        state_d   = ST_HOLD;
                        timeout_d = 1'b1;
                     end
                  end
               end
            end
            ST_TRACK: begin
               if (win_done && (avg_new >= thr_div)) begin
                  div_pulse_d = 1'b1;
                  state_d     = ST_CLEAR;
               end
            end
            ST_HOLD: begin
               if (start) state_d = ST_CLEAR;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // every (re)training pass starts with fresh counters and a cleared timeout flag
      if ((state_d == ST_CLEAR) && (state_q != ST_CLEAR)) begin
         clr_cnt_d = '0;
         win_cnt_d = 8'd0;
         timeout_d = 1'b0;
      end

      coef_clr_d  = (state_d == ST_CLEAR);
      converged_d = (state_d == ST_TRACK);
      case (state_d)
         ST_TRAIN: mu_shift_d = MU_TRAIN;
         ST_TRACK: mu_shift_d = MU_TRACK;
         default:  mu_shift_d = mu_shift_q;
      endcase
   end

   // controller state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         clr_cnt_q   <= '0;
         win_cnt_q   <= 8'd0;
         coef_clr_q  <= 1'b0;
         mu_shift_q  <= 3'd0;
         converged_q <= 1'b0;
         div_pulse_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         win_cnt_q   <= win_cnt_d;
         coef_clr_q  <= coef_clr_d;
         mu_shift_q  <= mu_shift_d;
         converged_q <= converged_d;
         div_pulse_q <= div_pulse_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus.coef_clr = coef_clr_q;
   assign bus.mu_shift = mu_shift_q;
   assign bus.adapt_en = bus.sample_en & adapting;
   assign state        = state_q;
   assign converged    = converged_q;
   assign div_pulse    = div_pulse_q;
   assign timeout      = timeout_q;

endmodule

// File: doc/lms_adapt_ctrl.md
Name: lms_adapt_ctrl

Overview:
- Adaptation controller for the sign-error LMS FIR datapath.
- Sequences coefficient clear, fast-training and slow-tracking phases, and gates coefficient updates per sample.
- Selects the step-size shift per phase, and monitors windowed mean |error| to declare convergence, divergence or training timeout.
- Sits beside the two-tap sign-LMS filter: consumes its error output, drives its coefficient-clear, update-enable and step-shift controls.

Parameters:
- EW, 16, error word width (signed, two's complement)
- WIN_LOG, 4, window length = 2^WIN_LOG samples
- CLR_CYC, 2, cycles coef_clr is held in CLEAR (>=1)
- MU_TRAIN, 3'd1, step-size right-shift used in TRAIN
- MU_TRACK, 3'd7, step-size right-shift used in TRACK
- MAX_WIN, 8'd32, windows allowed in TRAIN before timeout

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level/pulse; begins (re)training from IDLE or HOLD
- stop  in  1  abort to IDLE; highest priority
- sample_en  in  1  one-cycle strobe, new filter error valid
- e_in  in  EW  signed filter error (fir_out - d)
- thr_conv  in  EW  unsigned convergence threshold on window mean |e|
- thr_div  in  EW  unsigned divergence threshold on window mean |e|
- coef_clr  out  1  clear filter coefficients
- adapt_en  out  1  coefficient update enable for this sample
- mu_shift  out  3  step-size shift to datapath
- state  out  3  FSM state code
- converged  out  1  set on TRAIN->TRACK, cleared on leaving TRACK
- div_pulse  out  1  one-cycle pulse on divergence detection
- timeout  out  1  sticky; set on TRAIN timeout, cleared on start
- win_avg  out  EW  last completed window mean |e|

Behaviour:
- Reset (async, reset=0): state=IDLE, all outputs 0, mu_shift=0, win_avg=0, all counters and accumulator 0.
- State codes: IDLE=0, CLEAR=1, TRAIN=2, TRACK=3, HOLD=4. All outputs registered except adapt_en.
- adapt_en = sample_en & (state==TRAIN | state==TRACK). This path is combinational, zero latency.
- IDLE: start=1 -> CLEAR next edge.
- CLEAR: coef_clr=1 for exactly CLR_CYC cycles. Then -> TRAIN. Accumulator, sample count and window count cleared.
- TRAIN: mu_shift=MU_TRAIN.
- TRACK: mu_shift=MU_TRACK.
- IDLE, CLEAR, HOLD: mu_shift holds its last value.
- Window accumulation (TRAIN/TRACK), on each sample_en:
  - acc += |e_in|, with |-2^(EW-1)| saturated to 2^(EW-1)-1.
  - acc is EW+WIN_LOG bits and never overflows.
  - Sample counter counts up to 2^WIN_LOG-1.
- Window end (sample count wraps on a sample_en):
  - win_avg <= (acc + |e_in|) >> WIN_LOG.
  - acc restarts at 0.
  - The decision uses this new average in the same edge.
- TRAIN decision at window end:
  - avg < thr_conv -> TRACK, converged=1.
  - Otherwise increment the window count. If it reaches MAX_WIN -> HOLD, timeout=1.
- TRACK decision at window end: avg >= thr_div -> div_pulse=1 for one cycle, converged=0, -> CLEAR (automatic retrain).
- HOLD: adapt_en=0, coefficients frozen. start -> CLEAR and timeout cleared.
- stop=1 in any state -> IDLE next edge. stop overrides start and window decisions in the same cycle; converged clears. Partial window discarded.
- start while in CLEAR/TRAIN/TRACK: ignored.
- sample_en during CLEAR/IDLE/HOLD: ignored, no accumulation.
- reset asserted mid-window: immediate return to reset values; no pulse emitted.

Decomposition:
- Shared package lms_pkg holds:
  - state encodings (ST_IDLE..ST_HOLD)
  - default MU_TRAIN/MU_TRACK shifts
  - EW default
- Natural sub-module: lms_err_win. It takes the abs-saturate, accumulator, sample counter and window-end strobe, and outputs win_avg plus win_done. The FSM stays in lms_adapt_ctrl.

Test Plan:
1. Reset/idle:
   - Stimulus: reset low mid-operation, then high with no start.
   - Required: all outputs 0, state=0, adapt_en=0 even with sample_en toggling.
2. Clear then train, with WIN_LOG=4, thr_conv=64:
   - Stimulus: start pulse, then 16 samples e_in=+/-40 alternating.
   - Required: coef_clr high 2 cycles, state 1->2, mu_shift=1.
   - After the 16th sample: win_avg=40, state=3, converged=1, mu_shift=7.
3. Divergence, with thr_div=2048:
   - Stimulus: in TRACK, 16 samples e_in=-3000.
   - Required: win_avg=3000, div_pulse=1 for one cycle, converged=0, state=1 then 2.
4. Timeout, with MAX_WIN=2, thr_conv=64:
   - Stimulus: 32 samples e_in=500.
   - Required: state=4, timeout=1, adapt_en=0.
   - Then start: timeout=0, state=1.
5. Saturation:
   - Stimulus: 16 samples e_in=16'h8000.
   - Required: win_avg=16'h7FFF, no accumulator wrap.
6. Priority:
   - Stimulus: stop and start both high on the cycle of the 16th sample in TRAIN with avg<thr_conv.
   - Required: state=IDLE, converged=0, win_avg unchanged from its prior value.
